therm2bin_bubble: RTL and testbench

THERM2BIN_BUBBLE -- requirements
Module: therm2bin_bubble

---
 rtl/therm2bin_bubble.sv | 131 +++++++++++++
 tb/tb_therm2bin_bubble.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/therm2bin_bubble.sv
// Thermometer-to-binary encoder with 3-tap majority bubble correction, bubble
// detection, a configurable output delay line and a saturating bubble counter.
module therm2bin_bubble #(
  parameter int OUT_LENGTH  = 9,
  parameter int IN_LENGTH   = 128,
  parameter int PIPE_STAGES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [IN_LENGTH-1:0]  thermo,
  input  logic                  count_clr,
  output logic [OUT_LENGTH-1:0] bin,
  output logic                  valid_bin,
  output logic                  bubble_err,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
);

  typedef struct packed {
    logic                  valid;
    logic                  bubble;
    logic                  ovf;
    logic [OUT_LENGTH-1:0] bin;
  } result_t;

  logic [IN_LENGTH-1:0] raw_q;
  logic                 raw_vld_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its source, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw_q     <= '0;
      raw_vld_q <= 1'b0;
    end else begin
      raw_q     <= thermo;
      raw_vld_q <= valid;
    end
  end

  // Pad with t[-1]=1 below and t[IN_LENGTH]=0 above so the end taps vote too.
  logic [IN_LENGTH+1:0] ext;
  logic [IN_LENGTH-1:0] corr_d, corr_q;
  logic                 bub_d, bub_q, corr_vld_q;

  assign ext = {1'b0, raw_q, 1'b1};

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    corr_d = '0;
    for (int i = 0; i < IN_LENGTH; i++) begin
      corr_d[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
    bub_d = |(~raw_q[IN_LENGTH-2:0] & raw_q[IN_LENGTH-1:1]);
    if (!raw_vld_q) begin
      corr_d = '0;
      bub_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      corr_q     <= '0;
      bub_q      <= 1'b0;
      corr_vld_q <= 1'b0;
    end else begin
      corr_q     <= corr_d;
      bub_q      <= bub_d;
      corr_vld_q <= raw_vld_q;
    end
  end

  result_t res_d;

  always_comb begin
    res_d = '0;
    for (int i = 0; i < IN_LENGTH; i++) begin
      if (corr_q[i]) res_d.bin = OUT_LENGTH'(i + 1);
    end
    res_d.ovf    = corr_q[IN_LENGTH-1];
    res_d.bubble = bub_q;
    res_d.valid  = corr_vld_q;
    if (!corr_vld_q) begin
      res_d.bin    = '0;
      res_d.ovf    = 1'b0;
      res_d.bubble = 1'b0;
    end
  end

  // Entry 0 is the stage-3 register; entries 1..PIPE_STAGES form the delay line.
  result_t pipe_q [0:PIPE_STAGES];

  // NOTE: this register array is reset on purpose: in-flight samples must be
  // discarded on reset, so it is built from flops rather than an inferred RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= PIPE_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= res_d;
      for (int i = 1; i <= PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign bin        = pipe_q[PIPE_STAGES].bin;
  assign valid_bin  = pipe_q[PIPE_STAGES].valid;
  assign bubble_err = pipe_q[PIPE_STAGES].bubble;
  assign overflow   = pipe_q[PIPE_STAGES].ovf;

  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  // Clear wins over increment; the counter holds once it reaches all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (valid_bin && bubble_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_therm2bin_bubble.sv
// Directed bench for therm2bin_bubble: vector table streamed back to back,
// plus hand-written reset, latency and bubble-counter sequences.
module tb_therm2bin_bubble;
  localparam int OUT_LENGTH  = 9;
  localparam int IN_LENGTH   = 128;
  localparam int PIPE_STAGES = 4;
  localparam int CNT_WIDTH   = 16;
  localparam int LAT         = 3 + PIPE_STAGES;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  valid;
  logic [IN_LENGTH-1:0]  thermo;
  logic                  count_clr;
  logic [OUT_LENGTH-1:0] bin;
  logic                  valid_bin;
  logic                  bubble_err;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  bubble_cnt;

  therm2bin_bubble #(
    .OUT_LENGTH (OUT_LENGTH),
    .IN_LENGTH  (IN_LENGTH),
    .PIPE_STAGES(PIPE_STAGES),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .valid     (valid),
    .thermo    (thermo),
    .count_clr (count_clr),
    .bin       (bin),
    .valid_bin (valid_bin),
    .bubble_err(bubble_err),
    .overflow  (overflow),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [IN_LENGTH-1:0]  thermo;
    logic                  valid;
    logic [OUT_LENGTH-1:0] bin;
    logic                  vb;
    logic                  bub;
    logic                  ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [IN_LENGTH-1:0] ones(input int n);
    logic [IN_LENGTH-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic idle();
    valid  = 1'b0;
    thermo = '0;
  endtask

  // Drive one valid sample for a single cycle; returns at the following negedge.
  task automatic send_one(input logic [IN_LENGTH-1:0] t);
    @(negedge clock);
    thermo = t;
    valid  = 1'b1;
    @(negedge clock);
    idle();
  endtask

  logic [IN_LENGTH-1:0] w_bub31, w_bit1, w_bit127, w_hole64, w_alt;
  int lat;
  int vb_seen;
  logic [OUT_LENGTH-1:0] lat_bin;

  initial begin
    w_bub31 = ones(37);
    w_bub31[20] = 1'b0;
    w_bub31[50] = 1'b1;
    w_bit1 = '0;
    w_bit1[1] = 1'b1;
    w_bit127 = '0;
    w_bit127[127] = 1'b1;
    w_hole64 = '1;
    w_hole64[64] = 1'b0;
    w_alt = '0;
    for (int i = 0; i < IN_LENGTH; i += 2) w_alt[i] = 1'b1;

    //            thermo      vld bin  vb bub ovf
    vecs.push_back('{ones(37),   1'b1, 9'd37,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{w_bub31,    1'b1, 9'd37,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{'1,         1'b1, 9'd128, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{'0,         1'b1, 9'd0,   1'b1, 1'b0, 1'b0});
    vecs.push_back('{ones(37),   1'b0, 9'd0,   1'b0, 1'b0, 1'b0});
    vecs.push_back('{w_bit1,     1'b1, 9'd1,   1'b1, 1'b1, 1'b0});
    vecs.push_back('{w_bit127,   1'b1, 9'd0,   1'b1, 1'b1, 1'b0});
    vecs.push_back('{ones(127),  1'b1, 9'd127, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{w_hole64,   1'b1, 9'd128, 1'b1, 1'b1, 1'b1});
    vecs.push_back('{w_alt,      1'b1, 9'd126, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{'1,         1'b0, 9'd0,   1'b0, 1'b0, 1'b0});
    for (int n = 1; n <= 10; n++)
      vecs.push_back('{ones(n), 1'b1, OUT_LENGTH'(n), 1'b1, 1'b0, 1'b0});

    // Reset held with random traffic on the inputs: everything stays zero.
    reset     = 1'b1;
    count_clr = 1'b0;
    valid     = 1'b1;
    thermo    = {4{$urandom()}};
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("in-reset outputs %0d", k),
            32'({bin, valid_bin, bubble_err, overflow, bubble_cnt}), 32'd0);
      valid  = 1'($urandom_range(0, 1));
      thermo = {4{$urandom()}};
    end
    @(negedge clock);
    reset = 1'b0;
    idle();
    repeat (3) @(negedge clock);

    // First sample after reset: valid_bin appears exactly LAT cycles later.
    thermo = ones(5);
    valid  = 1'b1;
    lat    = -1;
    lat_bin = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) idle();
      if (valid_bin) begin
        lat     = k;
        lat_bin = bin;
        break;
      end
    end
    check("first latency", 32'(lat), 32'(LAT));
    check("first bin", 32'(lat_bin), 32'd5);
    repeat (3) @(negedge clock);

    // Bubbled word: corrected to 37, flagged, and counted once.
    check("cnt before bubble", 32'(bubble_cnt), 32'd0);
    send_one(w_bub31);
    repeat (LAT - 1) @(negedge clock);
    check("bubble word bin", 32'(bin), 32'd37);
    check("bubble word err", 32'(bubble_err), 32'd1);
    check("bubble word vb", 32'(valid_bin), 32'd1);
    @(negedge clock);
    check("cnt after bubble", 32'(bubble_cnt), 32'd1);

    // Table streamed back to back: result k appears LAT cycles after drive k.
    for (int k = 0; k < vecs.size() + LAT; k++) begin
      @(negedge clock);
      if (k >= LAT) begin
        int j;
        j = k - LAT;
        check($sformatf("vec%0d bin", j),        32'(bin),        32'(vecs[j].bin));
        check($sformatf("vec%0d valid_bin", j),  32'(valid_bin),  32'(vecs[j].vb));
        check($sformatf("vec%0d bubble_err", j), 32'(bubble_err), 32'(vecs[j].bub));
        check($sformatf("vec%0d overflow", j),   32'(overflow),   32'(vecs[j].ovf));
      end
      if (k < vecs.size()) begin
        thermo = vecs[k].thermo;
        valid  = vecs[k].valid;
      end else begin
        idle();
      end
    end
    @(negedge clock);
    check("cnt after table", 32'(bubble_cnt), 32'd6);

    // Five samples in flight, then an asynchronous reset pulse mid-cycle.
    for (int n = 1; n <= 5; n++) begin
      @(negedge clock);
      thermo = ones(n);
      valid  = 1'b1;
    end
    @(negedge clock);
    idle();
    #2 reset = 1'b1;
    #1 check("async reset outputs",
             32'({bin, valid_bin, bubble_err, overflow, bubble_cnt}), 32'd0);
    @(negedge clock);
    reset   = 1'b0;
    vb_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (valid_bin) vb_seen++;
    end
    check("valid_bin after flushed reset", 32'(vb_seen), 32'd0);

    // Drive the counter to all ones with a continuous bubble stream.
    for (int i = 0; i < 65535; i++) begin
      @(negedge clock);
      thermo = w_bit1;
      valid  = 1'b1;
    end
    @(negedge clock);
    idle();
    repeat (LAT + 2) @(negedge clock);
    check("cnt at saturation", 32'(bubble_cnt), 32'hFFFF);
    send_one(w_bit1);
    repeat (LAT + 2) @(negedge clock);
    check("cnt holds saturated", 32'(bubble_cnt), 32'hFFFF);

    // Clear coincident with a counted bubble: the clear wins.
    send_one(w_bit1);
    repeat (LAT - 1) @(negedge clock);
    check("bubble present at clear", 32'({valid_bin, bubble_err}), 32'd3);
    count_clr = 1'b1;
    @(negedge clock);
    count_clr = 1'b0;
    check("cnt after coincident clear", 32'(bubble_cnt), 32'd0);
    repeat (3) @(negedge clock);
    check("cnt stays cleared", 32'(bubble_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
